// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution datapath.
// Window element index is r*3+c, r=0 top row and c=0 left column.
package conv_pkg;

  localparam int unsigned COLOUR_DEPTH = 8;
  localparam int unsigned KERNAL_SIZE  = 9;

  typedef logic [COLOUR_DEPTH-1:0] pixel_t;
  typedef pixel_t window_t [KERNAL_SIZE];

  typedef enum logic [1:0] {
    FILL,
    STREAM,
    FLUSH
  } state_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of pixel storage: write on enable, read returns the pre-write contents.
module conv_line_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; callers never consume unwritten entries.
  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream in, fully populated 3x3 windows out (interior only, no padding).
// Two line buffers supply the upper rows; a 3-column shift register assembles the window.
module conv_window_gen #(
  parameter int unsigned KERNAL_WIDTH  = 3,
  parameter int unsigned KERNAL_HEIGHT = 3,
  parameter int unsigned COLOUR_DEPTH  = 8,
  parameter int unsigned IMG_WIDTH     = 64,
  parameter int unsigned IMG_HEIGHT    = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [COLOUR_DEPTH-1:0] s_pixel,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [COLOUR_DEPTH-1:0] data_mat [8:0],
  output logic                    m_last,
  output logic                    frame_done
);
  import conv_pkg::*;

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  if (KERNAL_WIDTH != 3 || KERNAL_HEIGHT != 3) begin : g_bad_kernel
    $error("conv_window_gen: only a 3x3 kernel is supported");
  end
  if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_image
    $error("conv_window_gen: image must be at least 3x3");
  end

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic [COLOUR_DEPTH-1:0] r_win [8:0];
  logic [COLOUR_DEPTH-1:0] w_win [8:0];
  logic [COLOUR_DEPTH-1:0] r_mat [8:0];
  logic                    r_m_valid;
  logic                    r_m_last;
  logic                    r_frame_done;
  logic [COLOUR_DEPTH-1:0] w_lb0_rd;
  logic [COLOUR_DEPTH-1:0] w_lb1_rd;
  logic                    w_accept;
  logic                    w_xfer;
  logic                    w_col_end;
  logic                    w_row_end;
  logic                    w_load;
  logic                    w_frame_end;

  assign w_accept    = s_valid && s_ready;
  assign w_xfer      = r_m_valid && m_ready;
  assign w_col_end   = (r_col == COL_LAST);
  assign w_row_end   = (r_row == ROW_LAST);
  assign w_load      = w_accept && (r_state == STREAM) && (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_frame_end = w_accept && (r_state == STREAM) && w_col_end && w_row_end;

  // Gated by reset so the source sees no readiness while the block is held in reset.
  assign s_ready = reset && (r_state != FLUSH) && (!r_m_valid || m_ready);

  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;
  assign frame_done = r_frame_done;
  assign data_mat   = r_mat;

  // lb0 holds the previous line, lb1 the line before that; lb1 is fed from lb0's old value.
  conv_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (COLOUR_DEPTH),
    .AW    (CW)
  ) u_lb0 (
    .clk     (clk),
    .i_en    (w_accept),
    .i_addr  (r_col),
    .i_wdata (s_pixel),
    .o_rdata (w_lb0_rd)
  );

  conv_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (COLOUR_DEPTH),
    .AW    (CW)
  ) u_lb1 (
    .clk     (clk),
    .i_en    (w_accept),
    .i_addr  (r_col),
    .i_wdata (w_lb0_rd),
    .o_rdata (w_lb1_rd)
  );

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_win[r*3]     = r_win[r*3+1];
      w_win[r*3+1]   = r_win[r*3+2];
    end
    w_win[2] = w_lb1_rd;
    w_win[5] = w_lb0_rd;
    w_win[8] = s_pixel;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      FILL:    if (w_accept && w_col_end && (r_row == RW'(1))) w_state_next = STREAM;
      STREAM:  if (w_frame_end) w_state_next = FLUSH;
      FLUSH:   if (w_xfer && r_m_last) w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= FILL;
      r_col        <= '0;
      r_row        <= '0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= '0;
        r_mat[i] <= '0;
      end
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= w_xfer && r_m_last;
      if (w_accept) begin
        r_win <= w_win;
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      // A load can only occur when the held window is free or leaving this cycle.
      if (w_load) begin
        r_mat     <= w_win;
        r_m_valid <= 1'b1;
        r_m_last  <= w_frame_end;
      end else if (w_xfer) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 5x4 image with pixel = base + row*16 + col.
module tb_conv_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  typedef logic [8:0][7:0] win_t;
  typedef struct packed {
    logic last;
    win_t w;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_pixel = '0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] data_mat [8:0];
  logic       m_last;
  logic       frame_done;

  int   n_checks = 0;
  int   n_fail = 0;
  int   fd_count = 0;
  int   cyc = 0;
  logic prev_last_xfer = 1'b0;

  exp_t exp_q[$];
  win_t got_q[$];
  logic got_last[$];
  int   got_cyc[$];

  conv_window_gen #(
    .KERNAL_WIDTH  (3),
    .KERNAL_HEIGHT (3),
    .COLOUR_DEPTH  (8),
    .IMG_WIDTH     (W),
    .IMG_HEIGHT    (H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_pixel    (s_pixel),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .data_mat   (data_mat),
    .m_last     (m_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic win_t win9(input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7,
                                input int a8);
    win_t w;
    w[0] = 8'(a0); w[1] = 8'(a1); w[2] = 8'(a2);
    w[3] = 8'(a3); w[4] = 8'(a4); w[5] = 8'(a5);
    w[6] = 8'(a6); w[7] = 8'(a7); w[8] = 8'(a8);
    return w;
  endfunction

  // Window whose bottom-right pixel is (r, c).
  function automatic win_t model_win(input int base, input int r, input int c);
    win_t w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i*3+j] = 8'(base + (r - 2 + i) * 16 + (c - 2 + j));
    return w;
  endfunction

  function automatic win_t cur_mat();
    win_t w;
    for (int i = 0; i < 9; i++) w[i] = data_mat[i];
    return w;
  endfunction

  // Monitor: pops one expectation for every window transfer.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (frame_done) begin
      fd_count++;
      check("frame_done_after_last", prev_last_xfer, 1'b1);
    end
    prev_last_xfer = 1'b0;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_window: got %0h, none expected", cur_mat());
      end else begin
        e = exp_q.pop_front();
        check("window", cur_mat(), e.w);
        check("m_last", m_last, e.last);
      end
      got_q.push_back(cur_mat());
      got_last.push_back(m_last);
      got_cyc.push_back(cyc);
      prev_last_xfer = m_last;
    end
  end

  task automatic send(input logic [7:0] v);
    bit acc = 1'b0;
    int n = 0;
    s_valid = 1'b1;
    s_pixel = v;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: pixel %0d not accepted, required within 100 cycles", v);
    end
  endtask

  task automatic send_frame(input int base, input bit gap);
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r >= 2 && c >= 2) begin
          e.last = (r == H - 1) && (c == W - 1);
          e.w    = model_win(base, r, c);
          exp_q.push_back(e);
        end
        send(8'(base + r * 16 + c));
        if (gap) begin
          s_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d windows outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_q.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic stall_first();
    int   n = 0;
    win_t snap;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!m_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL stall_wait: m_valid=0, required 1 within 200 cycles");
    end else begin
      snap = cur_mat();
      repeat (3) begin
        @(negedge clk);
        check("stall_data_stable", cur_mat(), snap);
        check("stall_m_valid", m_valid, 1'b1);
        check("stall_s_ready", s_ready, 1'b0);
      end
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
  endtask

  initial begin : stimulus
    int fd0;
    win_t first_w;
    win_t last_w;
    first_w = win9(0, 1, 2, 16, 17, 18, 32, 33, 34);
    last_w  = win9(18, 19, 20, 34, 35, 36, 50, 51, 52);

    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_data_mat", cur_mat(), '0);
    reset = 1'b1;
    #1;
    check("release_s_ready", s_ready, 1'b1);
    @(posedge clk);
    #1;

    // Continuous stream, consumer always ready.
    clear_got();
    fd0 = fd_count;
    send_frame(0, 1'b0);
    drain();
    check("s1_count", got_q.size(), 6);
    check("s1_frame_done", fd_count - fd0, 1);
    if (got_q.size() >= 6) begin
      check("s1_first", got_q[0], first_w);
      check("s1_last", got_q[5], last_w);
      check("s1_last_flag", got_last[5], 1'b1);
      check("s1_no_bubble_a", got_cyc[1] - got_cyc[0], 1);
      check("s1_no_bubble_b", got_cyc[2] - got_cyc[1], 1);
    end

    // Consumer stalls on the first window.
    clear_got();
    m_ready = 1'b0;
    fork
      send_frame(0, 1'b0);
      stall_first();
    join
    drain();
    check("s2_count", got_q.size(), 6);
    if (got_q.size() >= 2) begin
      check("s2_first", got_q[0], first_w);
      check("s2_second", got_q[1], win9(1, 2, 3, 17, 18, 19, 33, 34, 35));
    end

    // Input valid toggling every cycle.
    clear_got();
    fd0 = fd_count;
    send_frame(0, 1'b1);
    drain();
    check("s3_count", got_q.size(), 6);
    check("s3_frame_done", fd_count - fd0, 1);
    if (got_q.size() >= 6) begin
      check("s3_first", got_q[0], first_w);
      check("s3_last", got_q[5], last_w);
    end

    // Two frames back-to-back, holding the m_last window in FLUSH.
    clear_got();
    fd0 = fd_count;
    send_frame(0, 1'b0);
    m_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("flush_s_ready", s_ready, 1'b0);
      check("flush_m_last", m_last, 1'b1);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    check("flush_xfer_s_ready", s_ready, 1'b0);
    send_frame(128, 1'b0);
    drain();
    check("s4_count", got_q.size(), 12);
    check("s4_frame_done", fd_count - fd0, 2);
    if (got_q.size() >= 7) begin
      check("s4_f2_first", got_q[6], win9(128, 129, 130, 144, 145, 146, 160, 161, 162));
    end

    // Reset mid-frame while a window is pending, then a fresh frame.
    clear_got();
    m_ready = 1'b0;
    for (int p = 0; p <= 2 * W + 2; p++) send(8'((p / W) * 16 + (p % W)));
    s_pixel = 8'd35;
    s_valid = 1'b1;
    check("pre_reset_pending", m_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("async_rst_m_valid", m_valid, 1'b0);
    check("async_rst_s_ready", s_ready, 1'b0);
    check("async_rst_data", cur_mat(), '0);
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_m_valid", m_valid, 1'b0);
    s_valid = 1'b0;
    reset   = 1'b1;
    m_ready = 1'b1;
    fd0 = fd_count;
    send_frame(0, 1'b0);
    drain();
    check("s5_count", got_q.size(), 6);
    check("s5_frame_done", fd_count - fd0, 1);
    if (got_q.size() >= 6) begin
      check("s5_first", got_q[0], first_w);
      check("s5_last", got_q[5], last_w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Producer side of the 3x3 convolution datapath.
- Accepts a raster-order pixel stream (valid/ready), buffers two image lines, and emits every fully populated 3x3 window as the data_mat array consumed by the convolution processor.
- No padding: only interior windows are emitted, (IMG_WIDTH-2)*(IMG_HEIGHT-2) per frame.
- Sits between the image source (memory reader/DMA) and the conv datapath; one window per transfer.

Parameters:
- KERNAL_WIDTH, 3, window width; only 3 supported, elaboration error otherwise.
- KERNAL_HEIGHT, 3, window height; only 3 supported, elaboration error otherwise.
- COLOUR_DEPTH, 8, bits per pixel.
- IMG_WIDTH, 64, pixels per line; must be >= 3.
- IMG_HEIGHT, 64, lines per frame; must be >= 3.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- s_valid  input  1  input pixel valid.
- s_ready  output  1  block can accept a pixel.
- s_pixel  input  COLOUR_DEPTH  pixel, raster order (left to right, top to bottom).
- m_valid  output  1  window valid.
- m_ready  input  1  consumer accepts window.
- data_mat  output  COLOUR_DEPTH x 9 (unpacked [8:0])  window; index = r*3+c, r=0 top row, c=0 left column; [4] = centre.
- m_last  output  1  qualifies the final window of a frame.
- frame_done  output  1  one-cycle pulse when the last window of a frame transfers.

Behaviour:
- Reset values: s_ready=0 while reset asserted, 1 in the first cycle after release; m_valid=0, m_last=0, frame_done=0; data_mat=0; col=0, row=0; state=FILL.
- Line buffer contents are not reset. Stale data is never emitted because windows are suppressed for row<2.
- Input accept: s_valid && s_ready. Output transfer: m_valid && m_ready.
- s_ready = (state != FLUSH) && (!m_valid || m_ready). Single output register; a held window is never overwritten.
- On each pixel accept at (row, col):
  - lb1[col] <= lb0[col]; lb0[col] <= s_pixel (read-before-write at the same address).
  - Window shifts one column left.
  - New right column, top to bottom: {lb1[col], lb0[col], s_pixel}, using pre-write values.
- Window qualification: an accept at row>=2 && col>=2 loads data_mat and sets m_valid on the next edge.
  - Latency: 1 cycle from accept to m_valid.
  - The window centre is pixel (row-1, col-1).
- Column/row wrap: col increments to IMG_WIDTH-1, then returns to 0 and row increments. Shift-register carry-over across lines is harmless because col<2 suppresses output.
- m_valid clears on transfer unless a new window loads in the same cycle (simultaneous transfer + load keeps m_valid=1 with new data).
- FSM:
  - FILL: rows 0-1, no windows. Go to STREAM when an accept occurs at col=IMG_WIDTH-1, row=1.
  - STREAM: windows generated. On accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1): load the final window with m_last=1, reset row/col to 0, go to FLUSH.
  - FLUSH: s_ready=0. On transfer of the m_last window, pulse frame_done for 1 cycle and go to FILL. The next frame's first pixel can be accepted in the cycle after that transfer.
- Stall: while m_valid && !m_ready, data_mat, m_valid and m_last are held stable and s_ready=0.
- s_valid gaps: no state change, outputs held.
- Reset mid-frame: all counters, FSM and outputs return to reset values immediately (asynchronously). A partially delivered frame is dropped; the next pixel after release is treated as (0,0).
- Counter widths: col is $clog2(IMG_WIDTH) bits, row is $clog2(IMG_HEIGHT) bits. All pixel data passes through unmodified (no arithmetic).

Decomposition:
- Shared package conv_pkg holds:
  - COLOUR_DEPTH and KERNAL_SIZE (=9) constants.
  - typedef pixel_t, and window_t (array of 9 pixel_t).
  - FSM enum state_t {FILL, STREAM, FLUSH}.
- Sub-module conv_line_buffer: depth IMG_WIDTH, COLOUR_DEPTH wide, synchronous read-before-write, one read/write port pair, with an enable. Instantiated twice (lb0, lb1).

Test Plan:
- Parameters IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = row*16+col, s_valid=1, m_ready=1 -> exactly 6 windows.
  - First window, 1 cycle after accepting (2,2): data_mat = {0,1,2,16,17,18,32,33,34}.
  - Last window: {18,19,20,34,35,36,50,51,52} with m_last=1, then frame_done pulses once.
- Same frame, m_ready=0 for 3 cycles while the first window is pending -> data_mat stable, s_ready=0 throughout; no pixel lost; the second window is {1,2,3,17,18,19,33,34,35}.
- s_valid toggled 1/0 every cycle -> the same 6 windows in the same order; m_valid never asserted for col<2 or row<2.
- Two frames back-to-back, second with values +128 -> frame 2's first window is {128,129,130,144,145,146,160,161,162}; s_ready=0 during FLUSH until the m_last transfer.
- reset driven low at pixel (2,3) of a frame, held 2 cycles, then a fresh frame -> m_valid=0 immediately on assertion, and the fresh frame's first window equals the scenario-1 values exactly.
- Simultaneous transfer and new load (m_ready=1 continuously in STREAM) -> m_valid stays 1 for 3 consecutive windows of row 2 with no bubble.
